// File: rtl/adder_tree_multiplier.sv
// -----------------------------------------------------------------------------
// adder_tree_multiplier
//
// Unsigned N x N multiplier. The two operands are captured in enable-gated
// registers. The product is formed from N AND-gated, shifted partial products.
// These are summed pairwise by a binary adder tree of log2(N) levels, and the
// result is registered on P_out.
//
// Parameters
//   N          operand width in bits (power of two, 2..32), default 8
//
// Ports
//   clk        rising-edge clock for all state
//   Reset      asynchronous, active-low clear of every register
//   Data_in_A  multiplicand, captured into a_reg when EA=1
//   Data_in_B  multiplier, captured into b_reg when EB=1
//   EA, EB     independent load enables for the two operand registers
//   P_out      registered 2N-bit product of the held operands
//
// Build option
//   ADDER_TREE_PIPE_EN  when defined, registers the outputs of the first
//                       adder level. Latency rises from 2 to 3 clock edges,
//                       and throughput stays at one product per cycle.
// -----------------------------------------------------------------------------
module adder_tree_multiplier #(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [N-1:0]     Data_in_A,
    input  logic [N-1:0]     Data_in_B,
    input  logic             EA,
    input  logic             EB,
    output logic [2*N-1:0]   P_out
);

    localparam int unsigned W      = 2 * N;
    localparam int unsigned LEVELS = $clog2(N);
    localparam int unsigned HALF   = N / 2;

    // -------------------------------------------------------------------------
    // Operand registers
    // -------------------------------------------------------------------------
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (EA) begin
                a_reg <= Data_in_A;
            end
            if (EB) begin
                b_reg <= Data_in_B;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Partial products: row gi is A gated by multiplier bit gi, weighted by 2^gi
    // -------------------------------------------------------------------------
    logic [W-1:0] pp [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pp
            assign pp[gi] = b_reg[gi] ? (W'(a_reg) << gi) : '0;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // First adder level: adjacent pairs of partial products
    // -------------------------------------------------------------------------
    logic [W-1:0] lvl1_sum [HALF];
    logic [W-1:0] lvl1     [HALF];

    generate
        for (genvar gi = 0; gi < HALF; gi++) begin : g_lvl1
            assign lvl1_sum[gi] = pp[2*gi] + pp[2*gi+1];
        end
    endgenerate

`ifdef ADDER_TREE_PIPE_EN
    // The register after level one splits the longest path roughly in half.
    // It adds exactly one edge of latency to every product.
    logic [W-1:0] lvl1_reg [HALF];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < HALF; i++) begin
                lvl1_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < HALF; i++) begin
                lvl1_reg[i] <= lvl1_sum[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < HALF; gi++) begin : g_lvl1_sel
            assign lvl1[gi] = lvl1_reg[gi];
        end
    endgenerate
`else
    generate
        for (genvar gi = 0; gi < HALF; gi++) begin : g_lvl1_sel
            assign lvl1[gi] = lvl1_sum[gi];
        end
    endgenerate
`endif

    // -------------------------------------------------------------------------
    // Remaining adder levels 2..LEVELS
    //
    // Level gi holds N >> gi nodes, and each node adds two adjacent nodes of
    // the level below. Each level has its own scope, so no array is ever
    // partially driven.
    // -------------------------------------------------------------------------
    logic [W-1:0] tree_sum;

    generate
        for (genvar gi = 2; gi <= LEVELS; gi++) begin : g_lvl
            logic [W-1:0] node [N >> gi];
            for (genvar gj = 0; gj < (N >> gi); gj++) begin : g_node
                if (gi == 2) begin : g_from_lvl1
                    assign node[gj] = lvl1[2*gj] + lvl1[2*gj+1];
                end else begin : g_from_prev
                    assign node[gj] = g_lvl[gi-1].node[2*gj] + g_lvl[gi-1].node[2*gj+1];
                end
            end
        end

        // With N = 2, the first level already produces the whole sum.
        if (LEVELS == 1) begin : g_root_lvl1
            assign tree_sum = lvl1[0];
        end else begin : g_root_top
            assign tree_sum = g_lvl[LEVELS].node[0];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Product register: reloads every edge, so with both enables low it holds
    // the product of the held operands.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            P_out <= '0;
        end else begin
            P_out <= tree_sum;
        end
    end

endmodule

// File: tb/tb_adder_tree_multiplier.sv
// -----------------------------------------------------------------------------
// Testbench for adder_tree_multiplier (N = 8).
//
// The reference model keeps the held operand values. It computes their product
// with ordinary multiplication and delays it through a queue whose depth
// matches the build's latency. Directed table rows carry hand-computed
// products, and random traffic is checked only against the model.
// -----------------------------------------------------------------------------
module tb_adder_tree_multiplier;

    localparam int N = 8;
`ifdef ADDER_TREE_PIPE_EN
    localparam int LAT_EXTRA = 2;   // edges between operand load and P_out
`else
    localparam int LAT_EXTRA = 1;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   a_in  = '0;
    logic [N-1:0]   b_in  = '0;
    logic           ea    = 1'b0;
    logic           eb    = 1'b0;
    logic [2*N-1:0] p_out;

    adder_tree_multiplier #(.N(N)) dut (
        .clk       (clk),
        .Reset     (rst_n),
        .Data_in_A (a_in),
        .Data_in_B (b_in),
        .EA        (ea),
        .EB        (eb),
        .P_out     (p_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ------------------------------------------------------------------ model
    logic [N-1:0]   m_a;
    logic [N-1:0]   m_b;
    logic [2*N-1:0] m_exp;
    logic [2*N-1:0] m_pipe [$];

    function automatic logic [2*N-1:0] prod(input logic [N-1:0] x, input logic [N-1:0] y);
        return (2*N)'(x) * (2*N)'(y);
    endfunction

    function void model_clear();
        m_a   = '0;
        m_b   = '0;
        m_exp = '0;
        m_pipe.delete();
        for (int i = 0; i < LAT_EXTRA; i++) m_pipe.push_back('0);
    endfunction

    task automatic check(input string name, input logic [2*N-1:0] got, input logic [2*N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: P_out=0x%04h expected 0x%04h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Applies one clock edge, advances the model, and compares P_out at the
    // following falling edge.
    task automatic cycle(input string name);
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            m_exp = m_pipe.pop_front();
            if (ea) m_a = a_in;
            if (eb) m_b = b_in;
            m_pipe.push_back(prod(m_a, m_b));
        end
        @(negedge clk);
        cyc++;
        $display("cyc %0d %s: rst_n=%0b A=%0d B=%0d EA=%0b EB=%0b P_out=%0d model=%0d",
                 cyc, name, rst_n, a_in, b_in, ea, eb, p_out, m_exp);
        check(name, p_out, m_exp);
    endtask

    // ------------------------------------------------------------ table
    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic           ea;
        logic           eb;
        logic [2*N-1:0] exp;   // product of held operands after this row loads
    } vec_t;

    localparam int NV = 13;
    vec_t           tbl [NV];
    logic [2*N-1:0] q_tab [$];

    initial begin
        tbl[0]  = '{8'd12,  8'd13,  1'b1, 1'b1, 16'd156};
        tbl[1]  = '{8'd0,   8'd0,   1'b0, 1'b0, 16'd156};
        tbl[2]  = '{8'd77,  8'd88,  1'b0, 1'b0, 16'd156};
        tbl[3]  = '{8'hFF,  8'hFF,  1'b1, 1'b1, 16'hFE01};
        tbl[4]  = '{8'd0,   8'hAB,  1'b1, 1'b1, 16'd0};
        tbl[5]  = '{8'd7,   8'd0,   1'b1, 1'b0, 16'd1197};
        tbl[6]  = '{8'd100, 8'd9,   1'b0, 1'b1, 16'd63};
        tbl[7]  = '{8'd3,   8'd5,   1'b1, 1'b1, 16'd15};
        tbl[8]  = '{8'd6,   8'd7,   1'b1, 1'b1, 16'd42};
        tbl[9]  = '{8'd10,  8'd20,  1'b1, 1'b1, 16'd200};
        tbl[10] = '{8'd50,  8'd2,   1'b0, 1'b0, 16'd200};
        tbl[11] = '{8'd0,   8'd3,   1'b0, 1'b1, 16'd30};
        tbl[12] = '{8'd4,   8'd0,   1'b1, 1'b0, 16'd12};

        model_clear();

        // Reset held low with loads requested: everything stays zero.
        rst_n = 1'b0; ea = 1'b1; eb = 1'b1; a_in = 8'hFF; b_in = 8'hFF;
        repeat (3) begin
            cycle("reset_hold");
            check("reset_hold_zero", p_out, '0);
        end

        // Release between edges, and keep idle.
        rst_n = 1'b1; ea = 1'b0; eb = 1'b0;
        repeat (2) cycle("post_reset_idle");

        // Directed table. The row expectations emerge LAT_EXTRA edges later.
        for (int i = 0; i < NV; i++) begin
            a_in = tbl[i].a; b_in = tbl[i].b; ea = tbl[i].ea; eb = tbl[i].eb;
            cycle($sformatf("table_row%0d", i));
            q_tab.push_back(tbl[i].exp);
            if (q_tab.size() > LAT_EXTRA)
                check($sformatf("table_exp_row%0d", i - LAT_EXTRA), p_out, q_tab.pop_front());
        end
        ea = 1'b0; eb = 1'b0;
        for (int i = 0; i < LAT_EXTRA; i++) begin
            cycle("table_flush");
            check("table_exp_tail", p_out, q_tab.pop_front());
        end

        // Streaming, then asynchronous reset between clock edges.
        ea = 1'b1; eb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_in = 8'($urandom_range(1, 255));
            b_in = 8'($urandom_range(1, 255));
            cycle("stream_pre_reset");
        end
        #2 rst_n = 1'b0;
        model_clear();
        #1 check("async_reset_immediate", p_out, '0);
        cycle("stream_in_reset");
        rst_n = 1'b1; ea = 1'b0; eb = 1'b0;
        for (int i = 0; i <= LAT_EXTRA; i++) begin
            cycle("after_release_no_load");
            check("in_flight_discarded", p_out, '0);
        end

        // Random traffic, with occasional idle enables.
        for (int i = 0; i < 200; i++) begin
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            ea   = ($urandom_range(0, 3) != 0);
            eb   = ($urandom_range(0, 3) != 0);
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net that keeps the run from hanging.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_tree_multiplier.md
ADDER_TREE_MULTIPLIER -- requirements
Module: adder_tree_multiplier

Interface
REQ-001 Parameter: N, 8, unsigned operand width in bits; SHALL be a power of two, 2 to 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset, asynchronous and active-low.
REQ-004 Data_in_A  input  N  unsigned multiplicand.
REQ-005 Data_in_B  input  N  unsigned multiplier.
REQ-006 EA  input  1  load enable for operand register A.
REQ-007 EB  input  1  load enable for operand register B.
REQ-008 P_out  output  2N  registered unsigned product.

Function
REQ-009 Operand register A_reg (N bits) SHALL load Data_in_A on a rising clk edge when EA=1 and hold otherwise; B_reg likewise with Data_in_B/EB.
REQ-010 EA and EB SHALL be independent; either, both or neither may be asserted in a cycle.
REQ-011 Partial products SHALL be formed as pp[i] = (B_reg[i] ? A_reg : 0) shifted left by i, each zero-extended to 2N bits, i = 0..N-1.
REQ-012 Partial products SHALL be summed by a binary adder tree of log2(N) levels, each level adding adjacent pairs; no sequential shift-add or behavioural "*" operator.
REQ-013 P_out SHALL be a register updated every clk edge with the tree sum of the current A_reg and B_reg (default build).
REQ-014 Default latency: operands sampled at edge k (EA=EB=1) SHALL appear on P_out after edge k+1, i.e. 2 edges after inputs are applied.
REQ-015 Product SHALL be exact modulo 2^(2N); no overflow possible, no sign handling.
REQ-016 With enables low, P_out SHALL remain constant at the product of held operands.
REQ-017 Changing only one operand SHALL yield new_A*old_B (or old_A*new_B) at the same latency.

Reset
REQ-018 Reset=0 SHALL asynchronously clear A_reg, B_reg, P_out and any pipeline registers to 0, independent of clk.
REQ-019 While Reset=0, EA/EB SHALL be ignored and P_out SHALL read 0.
REQ-020 Reset asserted mid-operation SHALL discard in-flight products; after release, first non-zero P_out SHALL need a fresh load plus full latency.
REQ-021 Reset deassertion SHALL take effect at the next rising clk edge; first load may occur on that edge.

Configuration
REQ-022 Macro ADDER_TREE_PIPE_EN: when defined, a register stage SHALL be inserted after the first adder-tree level (also cleared by Reset), raising latency to 3 edges; throughput stays one product per cycle.
REQ-023 When ADDER_TREE_PIPE_EN is undefined, the tree SHALL be purely combinational between operand registers and P_out, latency 2 edges.

Verification (N=8, default build)
REQ-024 Reset=0 with EA=EB=1, A=0xFF, B=0xFF for 3 cycles -> P_out=0x0000 throughout.
REQ-025 After reset, load A=12, B=13 with EA=EB=1 -> P_out=156 (0x009C) two edges later, stable while enables low.
REQ-026 A=0xFF, B=0xFF -> P_out=0xFE01; A=0, B=0xAB -> P_out=0.
REQ-027 Hold A=7 loaded, then EB=1 only with B=9 while Data_in_A=100 and EA=0 -> P_out=63.
REQ-028 Back-to-back loads each cycle (3*5, 6*7, 10*20) -> P_out sequence 15, 42, 200 on consecutive cycles.
REQ-029 Assert Reset asynchronously between clk edges during streaming -> P_out becomes 0 immediately; 200 random pairs after release match A*B at stated latency (both macro settings).
